// File: rtl/data_mem_pkg.sv
// Shared definitions for the CPU data-side memory stage: word type, MMIO window
// base, MMIO register offsets and STATUS bit positions.
// Imported by mmio_timer and data_mem_mmio.
package data_mem_pkg;

   localparam int DW = 19;

   typedef logic [DW-1:0] word_t;

   // 256-word MMIO window; only bits [18:8] take part in the decode.
   localparam word_t MMIO_BASE = 19'h7FF00;

   localparam logic [7:0] OFF_LED      = 8'h00;
   localparam logic [7:0] OFF_COUNT    = 8'h01;
   localparam logic [7:0] OFF_CMP      = 8'h02;
   localparam logic [7:0] OFF_STATUS   = 8'h03;
   localparam logic [7:0] OFF_ERR_ADDR = 8'h04;

   // STATUS register bit indices.
   localparam int ST_IRQ = 0;
   localparam int ST_ERR = 1;
   localparam int ST_EN  = 2;

   typedef enum logic [1:0] {
      REG_RAM      = 2'd0,
      REG_MMIO     = 2'd1,
      REG_UNMAPPED = 2'd2
   } region_e;

   function automatic logic is_mmio(input word_t a);
      return a[DW-1:8] == MMIO_BASE[DW-1:8];
   endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running timer with compare match: on a match the counter reloads to 0
// and irq_pending is set (sticky until cleared by a write-1 to STATUS bit0).
// Ports: clk_i/rst_ni, write strobes for COUNT/CMP/STATUS with shared wdata_i,
//        count_o, cmp_o, enable_o, irq_o status for the readback mux.
module mmio_timer
   import data_mem_pkg::*;
(
   input  logic  clk_i,
   input  logic  rst_ni,
   input  logic  count_we_i,
   input  logic  cmp_we_i,
   input  logic  status_we_i,
   input  word_t wdata_i,
   output word_t count_o,
   output word_t cmp_o,
   output logic  enable_o,
   output logic  irq_o
);

   word_t count_q, count_d;
   word_t cmp_q, cmp_d;
   logic  enable_q, enable_d;
   logic  irq_q, irq_d;
   logic  match;

   // Match is only meaningful while running; a stopped timer never fires.
   assign match = enable_q && (count_q == cmp_q);

   always_comb begin
      count_d  = count_q;
      cmp_d    = cmp_q;
      enable_d = enable_q;
      irq_d    = irq_q;

      if (enable_q) begin
         count_d = match ? '0 : count_q + 19'd1;   // natural wrap 7FFFF -> 0
      end
      // Software load of COUNT overrides both increment and match reload.
      if (count_we_i) begin
         count_d = wdata_i;
      end

      if (cmp_we_i) begin
         cmp_d = wdata_i;
      end

      // New enable is registered here, so it only affects counting next cycle.
      if (status_we_i) begin
         enable_d = wdata_i[ST_EN];
         if (wdata_i[ST_IRQ]) begin
            irq_d = 1'b0;
         end
      end
      // Set after clear: a match coinciding with the W1C keeps the IRQ.
      if (match) begin
         irq_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q  <= '0;
         cmp_q    <= '0;
         enable_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         cmp_q    <= cmp_d;
         enable_q <= enable_d;
         irq_q    <= irq_d;
      end
   end

   assign count_o  = count_q;
   assign cmp_o    = cmp_q;
   assign enable_o = enable_q;
   assign irq_o    = irq_q;

endmodule

// File: rtl/data_mem_mmio.sv
// Data-side memory stage for the 19-bit single-cycle CPU: word-addressed RAM,
// MMIO window (LED, timer, STATUS, ERR_ADDR) and sticky unmapped-write capture.
// Ports: clk_i, rst_ni (async active-low), memwrite_i/addr_i/writedata_i from the
//        CPU, readdata_o (combinational from addr_i), led_o, timer_irq_o.
module data_mem_mmio
   import data_mem_pkg::*;
#(
   parameter int AW = 10
)(
   input  logic  clk_i,
   input  logic  rst_ni,
   input  logic  memwrite_i,
   input  word_t addr_i,
   input  word_t writedata_i,
   output word_t readdata_o,
   output logic  [7:0] led_o,
   output logic  timer_irq_o
);

   localparam int DEPTH = 2 ** AW;

   word_t         mem_q [DEPTH];
   logic [7:0]    led_q, led_d;
   logic          err_q, err_d;
   word_t         err_addr_q, err_addr_d;

   region_e       region;
   logic [7:0]    offset;
   logic [AW-1:0] ram_idx;

   logic          ram_we;
   logic          mmio_we;
   logic          bad_we;
   logic          count_we, cmp_we, status_we;

   word_t         t_count, t_cmp;
   logic          t_enable, t_irq;

   assign offset  = addr_i[7:0];
   assign ram_idx = addr_i[AW-1:0];

   // MMIO window sits far above any RAM depth, so the two regions never overlap.
   always_comb begin
      region = REG_UNMAPPED;
      if (is_mmio(addr_i)) begin
         region = REG_MMIO;
      end else if ((addr_i >> AW) == '0) begin
         region = REG_RAM;
      end
   end

   assign ram_we    = memwrite_i && (region == REG_RAM);
   assign mmio_we   = memwrite_i && (region == REG_MMIO);
   assign bad_we    = memwrite_i && (region == REG_UNMAPPED);
   assign count_we  = mmio_we && (offset == OFF_COUNT);
   assign cmp_we    = mmio_we && (offset == OFF_CMP);
   assign status_we = mmio_we && (offset == OFF_STATUS);

   // RAM has no reset; gating with rst_ni drops a store that collides with reset.
   always_ff @(posedge clk_i) begin
      if (ram_we && rst_ni) begin
         mem_q[ram_idx] <= writedata_i;
      end
   end

   always_comb begin
      led_d      = led_q;
      err_d      = err_q;
      err_addr_d = err_addr_q;

      if (mmio_we && (offset == OFF_LED)) begin
         led_d = writedata_i[7:0];
      end
      if (status_we && writedata_i[ST_ERR]) begin
         err_d = 1'b0;
      end
      // A fresh error wins over a simultaneous W1C.
      if (bad_we) begin
         err_d      = 1'b1;
         err_addr_d = addr_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         led_q      <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         led_q      <= led_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   mmio_timer u_timer (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .count_we_i  (count_we),
      .cmp_we_i    (cmp_we),
      .status_we_i (status_we),
      .wdata_i     (writedata_i),
      .count_o     (t_count),
      .cmp_o       (t_cmp),
      .enable_o    (t_enable),
      .irq_o       (t_irq)
   );

   always_comb begin
      readdata_o = '0;
      case (region)
         REG_RAM: readdata_o = mem_q[ram_idx];
         REG_MMIO: begin
            case (offset)
               OFF_LED:      readdata_o = {11'b0, led_q};
               OFF_COUNT:    readdata_o = t_count;
               OFF_CMP:      readdata_o = t_cmp;
               OFF_STATUS:   readdata_o = {16'b0, t_enable, err_q, t_irq};
               OFF_ERR_ADDR: readdata_o = err_addr_q;
               default:      readdata_o = '0;
            endcase
         end
         default: readdata_o = '0;
      endcase
   end

   assign led_o       = led_q;
   assign timer_irq_o = t_irq;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: RAM, LED, timer/compare/IRQ, wrap,
// collisions and unmapped-write capture, with hand-computed expectations.
module tb_data_mem_mmio;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        memwrite_i = 1'b0;
   logic [18:0] addr_i = '0;
   logic [18:0] writedata_i = '0;
   logic [18:0] readdata_o;
   logic [7:0]  led_o;
   logic        timer_irq_o;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [18:0] A_LED    = 19'h7FF00;
   localparam logic [18:0] A_COUNT  = 19'h7FF01;
   localparam logic [18:0] A_CMP    = 19'h7FF02;
   localparam logic [18:0] A_STATUS = 19'h7FF03;
   localparam logic [18:0] A_ERRA   = 19'h7FF04;

   data_mem_mmio dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .memwrite_i  (memwrite_i),
      .addr_i      (addr_i),
      .writedata_i (writedata_i),
      .readdata_o  (readdata_o),
      .led_o       (led_o),
      .timer_irq_o (timer_irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wr(input logic [18:0] a, input logic [18:0] d);
      addr_i      = a;
      writedata_i = d;
      memwrite_i  = 1'b1;
      cyc();
      memwrite_i  = 1'b0;
   endtask

   task automatic rd(input logic [18:0] a, output logic [18:0] d);
      addr_i = a;
      #1;
      d = readdata_o;
   endtask

   logic [18:0] v;

   initial begin
      // Reset state
      #12;
      rd(A_LED, v);    chk("rst_led_reg", v, 0);
      chk("rst_led_pin", led_o, 0);
      chk("rst_irq", timer_irq_o, 0);
      rd(A_COUNT, v);  chk("rst_count", v, 0);
      rd(A_STATUS, v); chk("rst_status", v, 0);
      rd(A_ERRA, v);   chk("rst_erraddr", v, 0);
      rst_ni = 1'b1;
      cyc();

      // 1 RAM
      wr(19'd4, 19'h12345);
      wr(19'd3, 19'h5A5A5);
      rd(19'd3, v); chk("ram_rd3", v, 19'h5A5A5);
      rd(19'd4, v); chk("ram_rd4", v, 19'h12345);
      addr_i = 19'd3; writedata_i = 19'h0AAAA; memwrite_i = 1'b1;
      #1 chk("ram_same_cycle_old", readdata_o, 19'h5A5A5);
      cyc(); memwrite_i = 1'b0;
      rd(19'd3, v); chk("ram_after_wr", v, 19'h0AAAA);

      // 2 LED
      wr(A_LED, 19'h7FFAB);
      chk("led_pin", led_o, 8'hAB);
      rd(A_LED, v); chk("led_rd", v, 19'h000AB);
      rd(19'h7FF10, v); chk("unlisted_off", v, 0);
      #2 rst_ni = 1'b0;
      #1 chk("led_async_rst", led_o, 0);
      rd(19'd3, v); chk("ram_kept_rst", v, 19'h0AAAA);
      cyc();
      rst_ni = 1'b1;
      cyc();

      // 3 Timer
      wr(A_CMP, 19'd5);
      wr(A_STATUS, 19'd4);
      rd(A_COUNT, v); chk("tmr_c0", v, 0);
      for (int i = 1; i <= 5; i++) begin
         cyc();
         rd(A_COUNT, v); chk($sformatf("tmr_c%0d", i), v, i);
      end
      chk("tmr_irq_before", timer_irq_o, 0);
      cyc();
      rd(A_COUNT, v); chk("tmr_reload", v, 0);
      chk("tmr_irq_set", timer_irq_o, 1);
      wr(A_STATUS, 19'd5);
      chk("tmr_irq_w1c", timer_irq_o, 0);
      rd(A_COUNT, v); chk("tmr_c_after_w1c", v, 1);

      // 4 Collisions
      repeat (4) cyc();
      rd(A_COUNT, v); chk("col_at_match", v, 5);
      wr(A_STATUS, 19'd5);
      chk("col_irq_kept", timer_irq_o, 1);
      rd(A_COUNT, v); chk("col_reload", v, 0);
      wr(A_COUNT, 19'd100);
      rd(A_COUNT, v); chk("col_load100", v, 100);
      cyc();
      rd(A_COUNT, v); chk("col_inc101", v, 101);

      // 5 Wrap
      wr(A_STATUS, 19'd1);
      chk("wrap_irq_clr", timer_irq_o, 0);
      wr(A_COUNT, 19'h7FFFE);
      wr(A_CMP, 19'd0);
      rd(A_COUNT, v); chk("wrap_held", v, 19'h7FFFE);
      wr(A_STATUS, 19'd4);
      rd(A_COUNT, v); chk("wrap_c0", v, 19'h7FFFE);
      cyc();
      rd(A_COUNT, v); chk("wrap_c1", v, 19'h7FFFF);
      cyc();
      rd(A_COUNT, v); chk("wrap_c2", v, 0);
      chk("wrap_irq_pre", timer_irq_o, 0);
      cyc();
      rd(A_COUNT, v); chk("wrap_c3", v, 0);
      chk("wrap_irq", timer_irq_o, 1);

      // 6 Unmapped write
      wr(19'd0, 19'h00777);
      rd(A_STATUS, v); chk("err_clean", v[1], 0);
      wr(19'h01000, 19'h11111);
      rd(A_STATUS, v); chk("err_set", v[1], 1);
      rd(A_ERRA, v);   chk("err_addr", v, 19'h01000);
      rd(19'd0, v);    chk("err_ram0", v, 19'h00777);
      rd(19'h01000, v); chk("err_rd0", v, 0);
      wr(A_STATUS, 19'd6);
      rd(A_STATUS, v); chk("err_w1c", v[1], 0);
      addr_i = 19'h01000;
      repeat (2) cyc();
      rd(A_STATUS, v); chk("err_rd_noerr", v[1], 0);
      rd(A_ERRA, v);   chk("erraddr_kept", v, 19'h01000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
